// File: rtl/fxp_pkg.sv
// rtl/fxp_pkg.sv - shared encodings and width helpers for the fixed-point multiplier
package fxp_pkg;

  typedef enum logic [1:0] {
    RND_TRUNC     = 2'd0,
    RND_HALF_UP   = 2'd1,
    RND_HALF_EVEN = 2'd2
  } rnd_mode_e;

  function automatic int prod_w(input int wi1, input int wf1, input int wi2, input int wf2);
    return wi1 + wf1 + wi2 + wf2;
  endfunction

  // Right-shift distance from the product binary point to the output binary point.
  function automatic int align_d(input int pf, input int wfo);
    return pf - wfo;
  endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// rtl/fxp_round_sat.sv - combinational align, round and saturate/wrap of a signed product
module fxp_round_sat
  import fxp_pkg::*;
#(
  parameter int PW     = 16,
  parameter int PF     = 12,
  parameter int WIO    = 2,
  parameter int WFO    = 6,
  parameter int SAT_EN = 1
) (
  input  logic signed [PW-1:0]      p,
  input  logic        [1:0]         rnd_mode,
  output logic        [WIO+WFO-1:0] res,
  output logic                      ovf
);

  localparam int D   = align_d(PF, WFO);
  localparam int LSH = (D < 0) ? -D : 0;
  localparam int RSH = (D > 0) ? D : 0;
  localparam int EW  = PW + LSH + 1;
  localparam int OW  = WIO + WFO;
  localparam int CW  = ((EW > OW) ? EW : OW) + 1;
  localparam int HB  = (RSH > 0) ? RSH - 1 : 0;
  localparam logic [EW-1:0] HALF = (RSH > 0) ? (EW'(1) << HB) : '0;

  logic signed [EW-1:0] pl;
  logic signed [EW-1:0] radd;
  logic signed [EW-1:0] sum;
  logic signed [EW-1:0] aligned;
  logic signed [CW-1:0] av;
  logic signed [CW-1:0] maxv;
  logic signed [CW-1:0] minv;

  // The extra top bit is the guard that keeps the rounding add from wrapping.
  assign pl = $signed({{(LSH+1){p[PW-1]}}, p}) <<< LSH;

  always_comb begin
    radd = '0;
    if (RSH > 0) begin
      case (rnd_mode)
        RND_HALF_UP:   radd = HALF;
        RND_HALF_EVEN: radd = HALF - EW'(1) + EW'(pl[RSH]);
        default:       radd = '0;
      endcase
    end
  end

  assign sum     = pl + radd;
  assign aligned = sum >>> RSH;
  assign av      = {{(CW-EW){aligned[EW-1]}}, aligned};
  assign maxv    = {{(CW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  assign minv    = {{(CW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  always_comb begin
    res = av[OW-1:0];
    ovf = 1'b0;
    if (av > maxv) begin
      ovf = 1'b1;
      if (SAT_EN != 0) res = maxv[OW-1:0];
    end else if (av < minv) begin
      ovf = 1'b1;
      if (SAT_EN != 0) res = minv[OW-1:0];
    end
  end

endmodule

// File: rtl/fxp_mult_pipe.sv
// rtl/fxp_mult_pipe.sv - 3-stage valid/ready signed fixed-point multiplier with channel tag
module fxp_mult_pipe
  import fxp_pkg::*;
#(
  parameter int WI1    = 2,
  parameter int WF1    = 6,
  parameter int WI2    = 2,
  parameter int WF2    = 6,
  parameter int WIO    = 2,
  parameter int WFO    = 6,
  parameter int CH_W   = 3,
  parameter int SAT_EN = 1,
  parameter int CNT_W  = 8
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WI1+WF1-1:0]   in1,
  input  logic [WI2+WF2-1:0]   in2,
  input  logic [1:0]           rnd_mode,
  input  logic [CH_W-1:0]      ch_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIO+WFO-1:0]   outMult,
  output logic [CH_W-1:0]      ch_out,
  output logic                 ovf,
  output logic                 ovf_sticky,
  output logic [CNT_W-1:0]     ovf_cnt,
  input  logic                 clr_ovf
);

  localparam int W1 = WI1 + WF1;
  localparam int W2 = WI2 + WF2;
  localparam int PW = prod_w(WI1, WF1, WI2, WF2);
  localparam int OW = WIO + WFO;

  logic                 v1, v2;
  logic [W1-1:0]        a1;
  logic [W2-1:0]        b1;
  logic [1:0]           m1, m2;
  logic [CH_W-1:0]      c1, c2;
  logic signed [PW-1:0] ax, bx, p2;
  logic                 adv1, adv2, adv3;
  logic [OW-1:0]        res_s3;
  logic                 ovf_s3;
  logic                 acc_ovf;

  // Each stage moves when it is empty or the stage after it is moving.
  assign adv3     = ~out_valid | out_ready;
  assign adv2     = ~v2 | adv3;
  assign adv1     = ~v1 | adv2;
  assign in_ready = adv1;

  assign ax = PW'($signed(a1));
  assign bx = PW'($signed(b1));

  fxp_round_sat #(
    .PW     (PW),
    .PF     (WF1 + WF2),
    .WIO    (WIO),
    .WFO    (WFO),
    .SAT_EN (SAT_EN)
  ) u_round_sat (
    .p        (p2),
    .rnd_mode (m2),
    .res      (res_s3),
    .ovf      (ovf_s3)
  );

  always_ff @(posedge CLK) begin
    if (adv1 && in_valid) begin
      a1 <= in1;
      b1 <= in2;
      m1 <= rnd_mode;
      c1 <= ch_in;
    end
    if (adv2 && v1) begin
      p2 <= ax * bx;
      m2 <= m1;
      c2 <= c1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      outMult   <= '0;
      ch_out    <= '0;
      ovf       <= 1'b0;
    end else begin
      if (adv1) v1 <= in_valid;
      if (adv2) v2 <= v1;
      if (adv3) begin
        out_valid <= v2;
        if (v2) begin
          outMult <= res_s3;
          ch_out  <= c2;
          ovf     <= ovf_s3;
        end
      end
    end
  end

  assign acc_ovf = out_valid & out_ready & ovf;

  // A simultaneous clear and overflow acceptance leaves exactly that one event recorded.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ovf_sticky <= 1'b0;
      ovf_cnt    <= '0;
    end else if (clr_ovf) begin
      ovf_sticky <= acc_ovf;
      ovf_cnt    <= acc_ovf ? CNT_W'(1) : '0;
    end else if (acc_ovf) begin
      ovf_sticky <= 1'b1;
      if (ovf_cnt != {CNT_W{1'b1}}) ovf_cnt <= ovf_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fxp_mult_pipe.sv
// tb/tb_fxp_mult_pipe.sv - scoreboard bench for saturating and wrapping multiplier instances
module tb_fxp_mult_pipe;

  logic       CLK = 1'b0;
  logic       RST_N, in_valid, out_ready, clr_ovf;
  logic [7:0] in1, in2;
  logic [1:0] rnd_mode;
  logic [2:0] ch_in;

  logic       in_ready, out_valid, ovf, ovf_sticky;
  logic [7:0] outMult, ovf_cnt;
  logic [2:0] ch_out;

  logic       w_in_ready, w_out_valid, w_ovf, w_sticky;
  logic [7:0] w_out;
  logic [2:0] w_ch;
  logic [1:0] w_cnt;

  int errors = 0;
  int checks = 0;
  logic [2:0] tag = 3'd0;

  typedef struct {
    logic [7:0] es;
    logic [7:0] ew;
    logic       eo;
    logic [2:0] ch;
  } exp_t;
  exp_t q[$];

  always #5 CLK = ~CLK;

  fxp_mult_pipe dut (
    .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .rnd_mode(rnd_mode), .ch_in(ch_in),
    .out_valid(out_valid), .out_ready(out_ready), .outMult(outMult), .ch_out(ch_out),
    .ovf(ovf), .ovf_sticky(ovf_sticky), .ovf_cnt(ovf_cnt), .clr_ovf(clr_ovf)
  );

  fxp_mult_pipe #(.SAT_EN(0), .CNT_W(2)) dutw (
    .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_ready(w_in_ready),
    .in1(in1), .in2(in2), .rnd_mode(rnd_mode), .ch_in(ch_in),
    .out_valid(w_out_valid), .out_ready(out_ready), .outMult(w_out), .ch_out(w_ch),
    .ovf(w_ovf), .ovf_sticky(w_sticky), .ovf_cnt(w_cnt), .clr_ovf(clr_ovf)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic sync();
    @(posedge CLK);
    #1;
  endtask

  // Caller sits just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m,
                      input logic [7:0] es, input logic [7:0] ew, input logic eo);
    exp_t e;
    int t;
    bit ok;
    t = 0;
    ok = 1'b1;
    in_valid = 1'b1; in1 = a; in2 = b; rnd_mode = m; ch_in = tag;
    forever begin
      @(negedge CLK);
      if (in_ready) break;
      t++;
      if (t > 200) begin
        checks++; errors++;
        $display("FAIL send_timeout: in_ready stuck 0, expected 1");
        ok = 1'b0;
        break;
      end
    end
    if (ok) begin
      e.es = es; e.ew = ew; e.eo = eo; e.ch = tag;
      q.push_back(e);
      tag = tag + 3'd1;
    end
    sync();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 500) begin
      @(negedge CLK);
      t++;
    end
    chk("drain_left", q.size(), 0);
    sync();
    sync();
  endtask

  // Monitor: pops on every transfer, checks held outputs while stalled.
  always @(negedge CLK) begin
    if (RST_N && out_valid) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output: got %0h expected none", outMult);
      end else if (out_ready) begin
        exp_t e;
        e = q.pop_front();
        chk("outMult", outMult, e.es);
        chk("ch_out", ch_out, e.ch);
        chk("ovf", ovf, e.eo);
        chk("w_valid", w_out_valid, 1);
        chk("w_outMult", w_out, e.ew);
        chk("w_ovf", w_ovf, e.eo);
      end else begin
        chk("held_outMult", outMult, q[0].es);
        chk("held_ch_out", ch_out, q[0].ch);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    RST_N = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_ovf = 1'b0;
    in1 = '0; in2 = '0; rnd_mode = '0; ch_in = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outMult", outMult, 0);
    chk("rst_ch_out", ch_out, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_sticky", ovf_sticky, 0);
    chk("rst_cnt", ovf_cnt, 0);
    sync();
    RST_N = 1'b1;
    @(negedge CLK);
    chk("rst_in_ready", in_ready, 1);

    // Latency: 0.5*0.5 in truncate mode.
    sync();
    send(8'h20, 8'h20, 2'd0, 8'h10, 8'h10, 1'b0);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!out_valid && n < 20);
    chk("latency", n, 3);

    sync();
    send(8'h01, 8'h20, 2'd0, 8'h00, 8'h00, 1'b0);
    send(8'h01, 8'h20, 2'd1, 8'h01, 8'h01, 1'b0);
    send(8'h01, 8'h20, 2'd2, 8'h00, 8'h00, 1'b0);
    send(8'h03, 8'h20, 2'd0, 8'h01, 8'h01, 1'b0);
    send(8'h03, 8'h20, 2'd1, 8'h02, 8'h02, 1'b0);
    send(8'h03, 8'h20, 2'd2, 8'h02, 8'h02, 1'b0);
    send(8'h03, 8'h20, 2'd3, 8'h01, 8'h01, 1'b0);
    send(8'hFF, 8'h20, 2'd0, 8'hFF, 8'hFF, 1'b0);
    send(8'hFF, 8'h20, 2'd1, 8'h00, 8'h00, 1'b0);
    send(8'hFF, 8'h20, 2'd2, 8'h00, 8'h00, 1'b0);
    send(8'h05, 8'h20, 2'd1, 8'h03, 8'h03, 1'b0);
    send(8'h05, 8'h20, 2'd2, 8'h02, 8'h02, 1'b0);
    send(8'h80, 8'h80, 2'd0, 8'h7F, 8'h00, 1'b1);
    send(8'h80, 8'h40, 2'd0, 8'h80, 8'h80, 1'b0);
    send(8'h7F, 8'h7F, 2'd0, 8'h7F, 8'hFC, 1'b1);
    send(8'h80, 8'h7F, 2'd0, 8'h80, 8'h02, 1'b1);
    send(8'hC0, 8'h40, 2'd0, 8'hC0, 8'hC0, 1'b0);
    drain();

    // Stream of 10 with a 5-cycle downstream stall.
    fork
      begin
        for (int i = 0; i < 10; i++)
          send(8'h40, 8'(i), 2'd0, 8'(i), 8'(i), 1'b0);
      end
      begin
        repeat (4) @(posedge CLK);
        #1;
        out_ready = 1'b0;
        repeat (5) @(negedge CLK);
        chk("stall_in_ready", in_ready, 0);
        sync();
        out_ready = 1'b1;
        @(negedge CLK);
        chk("resume_in_ready", in_ready, 1);
      end
    join
    drain();

    // Random downstream readiness.
    begin
      bit done;
      done = 1'b0;
      fork
        begin
          for (int i = 0; i < 12; i++)
            send(8'h40, 8'(i * 7), 2'd0, 8'(i * 7), 8'(i * 7), 1'b0);
          done = 1'b1;
        end
        begin
          while (!done) begin
            sync();
            out_ready = 1'($urandom_range(0, 1));
          end
          out_ready = 1'b1;
        end
      join
    end
    out_ready = 1'b1;
    drain();

    // Overflow status.
    clr_ovf = 1'b1;
    sync();
    clr_ovf = 1'b0;
    for (int i = 0; i < 3; i++) send(8'h80, 8'h80, 2'd0, 8'h7F, 8'h00, 1'b1);
    drain();
    chk("cnt3", ovf_cnt, 3);
    chk("sticky3", ovf_sticky, 1);
    chk("w_cnt3", w_cnt, 3);
    for (int i = 0; i < 2; i++) send(8'h80, 8'h7F, 2'd0, 8'h80, 8'h02, 1'b1);
    drain();
    chk("cnt5", ovf_cnt, 5);
    chk("w_cnt_hold", w_cnt, 3);
    chk("w_sticky", w_sticky, 1);
    clr_ovf = 1'b1;
    sync();
    clr_ovf = 1'b0;
    @(negedge CLK);
    chk("clr_cnt", ovf_cnt, 0);
    chk("clr_sticky", ovf_sticky, 0);
    chk("w_clr_cnt", w_cnt, 0);

    sync();
    out_ready = 1'b0;
    send(8'h80, 8'h80, 2'd0, 8'h7F, 8'h00, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("clr_setup_valid", out_valid, 1);
    sync();
    out_ready = 1'b1;
    clr_ovf = 1'b1;
    sync();
    clr_ovf = 1'b0;
    @(negedge CLK);
    chk("clrset_cnt", ovf_cnt, 1);
    chk("clrset_sticky", ovf_sticky, 1);
    chk("w_clrset_cnt", w_cnt, 1);
    drain();

    // Reset with three samples in flight.
    out_ready = 1'b0;
    send(8'h40, 8'h11, 2'd0, 8'h11, 8'h11, 1'b0);
    send(8'h40, 8'h12, 2'd0, 8'h12, 8'h12, 1'b0);
    send(8'h40, 8'h13, 2'd0, 8'h13, 8'h13, 1'b0);
    RST_N = 1'b0;
    sync();
    q.delete();
    RST_N = 1'b1;
    out_ready = 1'b1;
    @(negedge CLK);
    chk("post_rst_valid", out_valid, 0);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_w_in_ready", w_in_ready, 1);
    chk("post_rst_cnt", ovf_cnt, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("no_stale", out_valid | w_out_valid, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
